frog_collision_ctrl: RTL and testbench

FROG_COLLISION_CTRL -- requirements
Module: frog_collision_ctrl

---
 rtl/frogger_pkg.sv | 20 ++
 rtl/span_overlap.sv | 18 +
 rtl/frog_collision_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_frog_collision_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared constants and state type for the frog game controller.
package frogger_pkg;

    localparam logic [9:0]  BLOCKSIZE  = 10'd32;
    localparam logic [1:0]  LIVES_INIT = 2'd3;
    localparam logic [3:0]  LEVEL_INIT = 4'd1;
    localparam logic [3:0]  MAX_LEVEL  = 4'd9;
    localparam logic [2:0]  START_ROW  = 3'd6;
    localparam logic [2:0]  GOAL_ROW   = 3'd7;
    localparam int unsigned NUM_CARS   = 7;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlay     = 3'd1,
        StHit      = 3'd2,
        StWin      = 3'd3,
        StGameover = 3'd4
    } game_state_t;

endpackage

// File: rtl/span_overlap.sv
// Strict interval-overlap test between the frog span and one car span.
module span_overlap (
    input  logic [9:0] frog_x_i,
    input  logic [9:0] frog_w_i,
    input  logic [9:0] car_x_i,
    input  logic [9:0] car_len_i,
    output logic       overlap_o
);

    logic [10:0] frog_end;
    logic [10:0] car_end;

    // 11-bit sums so spans reaching past x=1023 do not wrap.
    assign frog_end  = {1'b0, frog_x_i} + {1'b0, frog_w_i};
    assign car_end   = {1'b0, car_x_i} + {1'b0, car_len_i};
    assign overlap_o = ({1'b0, frog_x_i} < car_end) && ({1'b0, car_x_i} < frog_end);

endmodule

// File: rtl/frog_collision_ctrl.sv
// Frog game controller: registered per-lane collision detect plus play/hit/win/game-over FSM.
module frog_collision_ctrl
    import frogger_pkg::*;
#(
    parameter logic [9:0]  BLOCKSIZE   = frogger_pkg::BLOCKSIZE,
    parameter logic [1:0]  LIVES_INIT  = frogger_pkg::LIVES_INIT,
    parameter logic [3:0]  LEVEL_INIT  = frogger_pkg::LEVEL_INIT,
    parameter logic [3:0]  MAX_LEVEL   = frogger_pkg::MAX_LEVEL,
    parameter logic [24:0] HOLD_CYCLES = 25'd25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] frog_x,
    input  logic [2:0] frog_row,
    input  logic [9:0] lane0_car0_x,
    input  logic [9:0] lane1_car0_x,
    input  logic [9:0] lane2_car0_x,
    input  logic [9:0] lane3_car0_x,
    input  logic [9:0] lane4_car0_x,
    input  logic [9:0] lane4_car1_x,
    input  logic [9:0] lane5_car0_x,
    input  logic [9:0] lane0_length,
    input  logic [9:0] lane1_length,
    input  logic [9:0] lane2_length,
    input  logic [9:0] lane3_length,
    input  logic [9:0] lane4_length,
    input  logic [9:0] lane5_length,
    output logic [3:0] level,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [2:0] state,
    output logic       hit,
    output logic       frog_respawn,
    output logic       cars_reset,
    output logic       game_over
);

    logic [9:0]          car_x   [NUM_CARS];
    logic [9:0]          car_len [NUM_CARS];
    logic [NUM_CARS-1:0] ovl;
    logic                row_hit;

    game_state_t state_q, state_d;
    logic [3:0]  level_q, level_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  score_q, score_d;
    logic [24:0] timer_q, timer_d;
    logic        hit_q, hit_d;
    logic        respawn_q, respawn_d;
    logic        cars_reset_q, cars_reset_d;
    logic        game_over_q, game_over_d;
    logic        coll_q, coll_d;
    logic        start_q;
    logic        hold_done;

    // Index 6 is the second lane-4 car.
    assign car_x   = '{lane0_car0_x, lane1_car0_x, lane2_car0_x, lane3_car0_x,
                       lane4_car0_x, lane5_car0_x, lane4_car1_x};
    assign car_len = '{lane0_length, lane1_length, lane2_length, lane3_length,
                       lane4_length, lane5_length, lane4_length};

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_span
        span_overlap u_span (
            .frog_x_i  (frog_x),
            .frog_w_i  (BLOCKSIZE),
            .car_x_i   (car_x[i]),
            .car_len_i (car_len[i]),
            .overlap_o (ovl[i])
        );
    end

    always_comb begin
        row_hit = 1'b0;
        case (frog_row)
            3'd0:    row_hit = ovl[0];
            3'd1:    row_hit = ovl[1];
            3'd2:    row_hit = ovl[2];
            3'd3:    row_hit = ovl[3];
            3'd4:    row_hit = ovl[4] | ovl[6];
            3'd5:    row_hit = ovl[5];
            default: row_hit = 1'b0;
        endcase
    end

    assign hold_done = (timer_q == HOLD_CYCLES - 25'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            level_q      <= LEVEL_INIT;
            lives_q      <= LIVES_INIT;
            score_q      <= 8'd0;
            timer_q      <= 25'd0;
            hit_q        <= 1'b0;
            respawn_q    <= 1'b0;
            cars_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
            coll_q       <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            timer_q      <= timer_d;
            hit_q        <= hit_d;
            respawn_q    <= respawn_d;
            cars_reset_q <= cars_reset_d;
            game_over_q  <= game_over_d;
            coll_q       <= coll_d;
            start_q      <= start;
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        score_d      = score_q;
        timer_d      = timer_q;
        hit_d        = 1'b0;
        respawn_d    = 1'b0;
        cars_reset_d = 1'b0;
        // Collisions are only sampled while playing, so a hold never carries a stale hit out.
        coll_d       = row_hit && (state_q == StPlay);

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StPlay;
                    respawn_d    = 1'b1;
                    cars_reset_d = 1'b1;
                    lives_d      = LIVES_INIT;
                    level_d      = LEVEL_INIT;
                    score_d      = 8'd0;
                    timer_d      = 25'd0;
                end
            end
            StPlay: begin
                if (coll_q) begin
                    state_d = StHit;
                    hit_d   = 1'b1;
                    timer_d = 25'd0;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end else if (frog_row == GOAL_ROW) begin
                    state_d = StWin;
                    timer_d = 25'd0;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                end
            end
            StHit: begin
                if (hold_done) begin
                    if (lives_q == 2'd0) begin
                        state_d = StGameover;
                    end else begin
                        state_d   = StPlay;
                        respawn_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 25'd1;
                end
            end
            StWin: begin
                if (hold_done) begin
                    state_d      = StPlay;
                    respawn_d    = 1'b1;
                    cars_reset_d = 1'b1;
                    if (level_q < MAX_LEVEL) level_d = level_q + 4'd1;
                end else begin
                    timer_d = timer_q + 25'd1;
                end
            end
            StGameover: begin
                if (start && !start_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        game_over_d = (state_d == StGameover);
    end

    always_comb begin
        state        = state_q;
        level        = level_q;
        lives        = lives_q;
        score        = score_q;
        hit          = hit_q;
        frog_respawn = respawn_q;
        cars_reset   = cars_reset_q;
        game_over    = game_over_q;
    end

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Scoreboard bench: stimulus queues expected pulse-cycle snapshots, a negedge monitor checks them.
module tb_frog_collision_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_HIT = 3'd2, S_WIN = 3'd3, S_GO = 3'd4;

    typedef struct packed {
        logic       hit;
        logic       resp;
        logic       cars;
        logic [2:0] st;
        logic [1:0] lives;
        logic [3:0] level;
        logic [7:0] score;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] frog_x = 10'd0;
    logic [2:0] frog_row = 3'd6;
    logic [9:0] l0x = 10'd0, l1x = 10'd0, l2x = 10'd0, l3x = 10'd0;
    logic [9:0] l4x = 10'd0, l4x1 = 10'd0, l5x = 10'd0;
    logic [9:0] l0n = 10'd0, l1n = 10'd0, l2n = 10'd0, l3n = 10'd0, l4n = 10'd0, l5n = 10'd0;
    logic [3:0] level;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] state;
    logic       hit, frog_respawn, cars_reset, game_over;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t exp_q[$];
    ev_t mon_got, mon_exp;
    logic prev_hit = 1'b0, prev_resp = 1'b0, prev_cars = 1'b0;

    logic [1:0] m_lives;
    logic [3:0] m_level;
    logic [7:0] m_score;

    frog_collision_ctrl #(.HOLD_CYCLES(25'd4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frog_x       (frog_x),
        .frog_row     (frog_row),
        .lane0_car0_x (l0x),
        .lane1_car0_x (l1x),
        .lane2_car0_x (l2x),
        .lane3_car0_x (l3x),
        .lane4_car0_x (l4x),
        .lane4_car1_x (l4x1),
        .lane5_car0_x (l5x),
        .lane0_length (l0n),
        .lane1_length (l1n),
        .lane2_length (l2n),
        .lane3_length (l3n),
        .lane4_length (l4n),
        .lane5_length (l5n),
        .level        (level),
        .lives        (lives),
        .score        (score),
        .state        (state),
        .hit          (hit),
        .frog_respawn (frog_respawn),
        .cars_reset   (cars_reset),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk_ev(logic h, logic r, logic c, logic [2:0] s);
        mk_ev = '{hit: h, resp: r, cars: c, st: s, lives: m_lives, level: m_level, score: m_score};
    endfunction

    // Monitor: every cycle carrying a pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && (hit || frog_respawn || cars_reset)) begin
            mon_got = '{hit: hit, resp: frog_respawn, cars: cars_reset, st: state,
                        lives: lives, level: level, score: score};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got %h, required no pulse", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pulse_event: got %h, required %h", mon_got, mon_exp);
                end
            end
            n_checks++;
            if ({hit & prev_hit, frog_respawn & prev_resp, cars_reset & prev_cars} !== 3'b000) begin
                n_fail++;
                $display("FAIL pulse_twice: got %b%b%b, required single-cycle pulses",
                         hit, frog_respawn, cars_reset);
            end
        end
        prev_hit  <= hit;
        prev_resp <= frog_respawn;
        prev_cars <= cars_reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic wait_resp(input string name, input int req_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frog_respawn && n < 40);
        chk(name, n, req_n);
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int req_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (state !== s && n < 40);
        chk(name, n, req_n);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_start();
        m_lives = 2'd3;
        m_level = 4'd1;
        m_score = 8'd0;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b1, S_PLAY));
        start = 1'b1;
        tick();
        start = 1'b0;
        drain("start_drain");
    endtask

    task automatic do_win(input logic check_state);
        frog_row = 3'd7;
        if (m_score != 8'hFF) m_score = m_score + 8'd1;
        if (m_level < 4'd9) m_level = m_level + 4'd1;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b1, S_PLAY));
        tick();
        if (check_state) chk("win_state", state, S_WIN);
        wait_resp("win_hold", 4);
        frog_row = 3'd6;
    endtask

    // Lane-2 hit from PLAY with frog left in the lane through the hold.
    task automatic do_hit_lane2();
        frog_row = 3'd2;
        frog_x   = 10'd200;
        l2x      = 10'd150;
        l2n      = 10'd96;
        m_lives  = m_lives - 2'd1;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, S_HIT));
        tick();
        chk("hit_lat1", {state, hit}, {S_PLAY, 1'b0});
        tick();
        chk("hit_lat2", {state, hit}, {S_HIT, 1'b1});
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, S_PLAY));
        wait_resp("hit_hold", 4);
        frog_row = 3'd6;
        drain("hit_drain");
    endtask

    initial begin
        #2;
        tick();
        chk("rst_state", {state, lives, level, score}, {S_IDLE, 2'd3, 4'd1, 8'd0});
        chk("rst_flags", {hit, frog_respawn, cars_reset, game_over}, 4'b0000);
        reset = 1'b1;
        tick();
        chk("idle_wait", state, S_IDLE);

        do_start();
        chk("play_init", {state, lives, level, score}, {S_PLAY, 2'd3, 4'd1, 8'd0});

        do_hit_lane2();
        chk("after_hit1", {state, lives}, {S_PLAY, 2'd2});

        // Touching edges do not collide; one pixel of overlap does.
        frog_row = 3'd2;
        frog_x   = 10'd246;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("edge_touch", {state, hit}, {S_PLAY, 1'b0});
        end
        frog_x  = 10'd245;
        m_lives = 2'd1;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, S_HIT));
        tick();
        tick();
        chk("edge_hit", {state, hit, lives}, {S_HIT, 1'b1, 2'd1});
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, S_PLAY));
        wait_resp("edge_hold", 4);
        frog_row = 3'd6;
        drain("edge_drain");

        for (int i = 0; i < 256; i++) do_win(i < 3 || i == 255);
        drain("win_drain");
        chk("win_sat", {state, level, score, lives}, {S_PLAY, 4'd9, 8'd255, 2'd1});

        // Lane-4 second car: safe on the start row, fatal on row 4.
        frog_row = 3'd6;
        frog_x   = 10'd400;
        l4x      = 10'd96;
        l4x1     = 10'd396;
        l4n      = 10'd64;
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lane4_safe", {state, hit}, {S_PLAY, 1'b0});
        end
        frog_row = 3'd4;
        m_lives  = 2'd0;
        exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, S_HIT));
        tick();
        tick();
        chk("lane4_hit", {state, hit, lives}, {S_HIT, 1'b1, 2'd0});
        wait_state("go_hold", S_GO, 4);
        frog_row = 3'd6;
        chk("go_flags", {game_over, lives}, {1'b1, 2'd0});
        repeat (5) tick();
        chk("go_start_held", {state, game_over}, {S_GO, 1'b1});
        start = 1'b0;
        tick();
        chk("go_start_low", state, S_GO);
        start = 1'b1;
        tick();
        chk("go_edge_idle", {state, game_over}, {S_IDLE, 1'b0});
        m_lives = 2'd3;
        m_level = 4'd1;
        m_score = 8'd0;
        exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b1, S_PLAY));
        tick();
        start = 1'b0;
        drain("restart_drain");

        // Reset mid-PLAY with lives=2, level=3.
        do_win(1'b0);
        do_win(1'b0);
        drain("pre_rst_drain");
        do_hit_lane2();
        chk("pre_rst", {state, lives, level, score}, {S_PLAY, 2'd2, 4'd3, 8'd2});
        reset = 1'b0;
        tick();
        chk("rst_play", {state, lives, level, score}, {S_IDLE, 2'd3, 4'd1, 8'd0});
        chk("rst_play_pulses", {hit, frog_respawn, cars_reset, game_over}, 4'b0000);
        reset = 1'b1;

        // Reset mid-WIN abandons the hold.
        do_start();
        frog_row = 3'd7;
        tick();
        tick();
        chk("mid_win", {state, score}, {S_WIN, 8'd1});
        reset = 1'b0;
        tick();
        chk("rst_win", {state, level, score}, {S_IDLE, 4'd1, 8'd0});
        reset    = 1'b1;
        frog_row = 3'd6;
        repeat (8) tick();
        chk("rst_win_quiet", {state, exp_q.size() == 0}, {S_IDLE, 1'b1});

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
